// File: rtl/rx_fc_pkg.sv
// Shared definitions for the receive-side flow-control credit tracker.
// Credit type encodings, type index width and UpdateFC state machine states.
package rx_fc_pkg;

    localparam int FC_NUM_TYPES = 6;
    localparam int TYPE_W       = $clog2(FC_NUM_TYPES);

    localparam logic [TYPE_W-1:0] PH   = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] PD   = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] NPH  = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] NPD  = TYPE_W'(3);
    localparam logic [TYPE_W-1:0] CPLH = TYPE_W'(4);
    localparam logic [TYPE_W-1:0] CPLD = TYPE_W'(5);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } fc_state_t;

endpackage

// File: rtl/rx_fc_fifo.sv
// Per-type receive buffer with registered read data.
// Pointers carry one wrap bit so full and empty are distinguishable.
module rx_fc_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Storage array; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // Pointer advance and registered read-out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/rx_fc_credit_tracker.sv
// Receive buffers per credit type plus credit-limit tracking.
// Returned credits are advertised via round-robin UpdateFC requests.
module rx_fc_credit_tracker
    import rx_fc_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int NUM_TYPES     = 6,
    parameter int CREDIT_WIDTH  = 12,
    parameter int UPDATE_PERIOD = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [TYPE_W-1:0]                 in_type,
    input  logic [DATA_WIDTH-1:0]             in_data,
    output logic                              in_ready,
    input  logic [NUM_TYPES-1:0]              rd_en,
    output logic [NUM_TYPES*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_TYPES-1:0]              empty,
    output logic [NUM_TYPES-1:0]              full,
    output logic [NUM_TYPES*CREDIT_WIDTH-1:0] credit_limit,
    output logic                              fc_valid,
    output logic [TYPE_W-1:0]                 fc_type,
    output logic [CREDIT_WIDTH-1:0]           fc_credit,
    input  logic                              fc_ready,
    output logic [NUM_TYPES-1:0]              overflow_err,
    output logic                              type_err
);

    logic [NUM_TYPES-1:0]    wr_en;
    logic [NUM_TYPES-1:0]    rd_ok;
    logic [NUM_TYPES-1:0]    pend;
    logic [NUM_TYPES-1:0]    clr;
    logic [CREDIT_WIDTH-1:0] limit_q [NUM_TYPES];
    logic [TYPE_W-1:0]       rr_ptr;
    logic [TYPE_W-1:0]       grant;
    logic [TYPE_W-1:0]       idx;
    logic                    any;
    logic                    type_ok;
    logic                    sel_full;
    logic                    refresh;
    fc_state_t               state;

    // Ingress acceptance: refuse out-of-range types and full buffers.
    always_comb begin
        type_ok  = (32'(in_type) < NUM_TYPES);
        sel_full = 1'b0;
        wr_en    = '0;
        for (int i = 0; i < NUM_TYPES; i++) begin
            if (in_type == TYPE_W'(i)) sel_full = full[i];
        end
        in_ready = type_ok && !sel_full;
        for (int i = 0; i < NUM_TYPES; i++) begin
            wr_en[i] = in_valid && in_ready && (in_type == TYPE_W'(i));
        end
    end

    assign rd_ok = rd_en & ~empty;

    for (genvar i = 0; i < NUM_TYPES; i++) begin : g_type
        rx_fc_fifo #(
            .DATA_WIDTH(DATA_WIDTH),
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (wr_en[i]),
            .wr_data(in_data),
            .rd_en  (rd_en[i]),
            .rd_data(rd_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .empty  (empty[i]),
            .full   (full[i])
        );
        assign credit_limit[i*CREDIT_WIDTH +: CREDIT_WIDTH] = limit_q[i];
    end

    if (UPDATE_PERIOD > 0) begin : g_tmr
        localparam int TMR_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
        logic [TMR_W-1:0] timer;
        assign refresh = (timer == TMR_W'(UPDATE_PERIOD - 1));
        // Free-running refresh timer forcing a periodic UpdateFC sweep.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)          timer <= '0;
            else if (refresh) timer <= '0;
            else              timer <= timer + 1'b1;
        end
    end else begin : g_no_tmr
        assign refresh = 1'b0;
    end

    // Credit limits advance only when the consumer frees a buffer slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TYPES; i++) limit_q[i] <= CREDIT_WIDTH'(FIFO_DEPTH);
        end else begin
            for (int i = 0; i < NUM_TYPES; i++) begin
                if (rd_ok[i]) limit_q[i] <= limit_q[i] + 1'b1;
            end
        end
    end

    // Round-robin pick of the first pending type starting at rr_ptr.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        clr   = '0;
        for (int k = 0; k < NUM_TYPES; k++) begin
            idx = TYPE_W'((int'(rr_ptr) + k) % NUM_TYPES);
            if (!any && pend[idx]) begin
                any   = 1'b1;
                grant = idx;
            end
        end
        if (state == IDLE && any) clr[grant] = 1'b1;
    end

    // UpdateFC state machine; new reads re-arm pend even mid-send.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pend      <= '0;
            rr_ptr    <= '0;
            fc_valid  <= 1'b0;
            fc_type   <= '0;
            fc_credit <= '0;
        end else begin
            pend <= (pend & ~clr) | rd_ok | {NUM_TYPES{refresh}};
            unique case (state)
                IDLE: begin
                    if (any) begin
                        state     <= SEND;
                        fc_valid  <= 1'b1;
                        fc_type   <= grant;
                        fc_credit <= limit_q[grant];
                    end
                end
                SEND: begin
                    if (fc_ready) begin
                        state    <= IDLE;
                        fc_valid <= 1'b0;
                        rr_ptr   <= (fc_type == TYPE_W'(NUM_TYPES - 1)) ?
                                    '0 : fc_type + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error flags for dropped ingress words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_err <= '0;
            type_err     <= 1'b0;
        end else if (in_valid && !in_ready) begin
            if (type_ok) overflow_err <= overflow_err | (NUM_TYPES'(1) << in_type);
            else         type_err     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rx_fc_credit_tracker.sv
// Self-checking bench for rx_fc_credit_tracker.
// Directed scenarios plus a randomized run against a queue-based model.
module tb_rx_fc_credit_tracker;
    import rx_fc_pkg::*;

    localparam int NT = 6;
    localparam int DW = 8;
    localparam int CW = 12;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic [TYPE_W-1:0] in_type = '0;
    logic [DW-1:0] in_data = '0;
    logic in_ready;
    logic [NT-1:0] rd_en = '0;
    logic [NT*DW-1:0] rd_data;
    logic [NT-1:0] empty, full;
    logic [NT*CW-1:0] credit_limit;
    logic fc_valid;
    logic [TYPE_W-1:0] fc_type;
    logic [CW-1:0] fc_credit;
    logic fc_ready = 1'b0;
    logic [NT-1:0] overflow_err;
    logic type_err;

    logic rst8 = 1'b1;
    logic fc_ready8 = 1'b0;
    logic in_ready8;
    logic [NT*DW-1:0] rd_data8;
    logic [NT-1:0] empty8, full8;
    logic [NT*CW-1:0] credit_limit8;
    logic fc_valid8;
    logic [TYPE_W-1:0] fc_type8;
    logic [CW-1:0] fc_credit8;
    logic [NT-1:0] overflow_err8;
    logic type_err8;

    int n_chk = 0;
    int n_fail = 0;

    int mon_t[$];
    int mon_c[$];
    int fcv_cycles;
    logic [CW-1:0] mon_last [NT];
    bit mon_seen [NT];

    int mon8_t[$];
    int mon8_c[$];
    int mon8_cyc[$];
    int cyc8;

    always #5 clk = ~clk;

    rx_fc_credit_tracker dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_type(in_type), .in_data(in_data),
        .in_ready(in_ready), .rd_en(rd_en), .rd_data(rd_data),
        .empty(empty), .full(full), .credit_limit(credit_limit),
        .fc_valid(fc_valid), .fc_type(fc_type), .fc_credit(fc_credit),
        .fc_ready(fc_ready), .overflow_err(overflow_err),
        .type_err(type_err)
    );

    rx_fc_credit_tracker #(.UPDATE_PERIOD(8)) dut8 (
        .clk(clk), .rst(rst8),
        .in_valid(1'b0), .in_type('0), .in_data('0),
        .in_ready(in_ready8), .rd_en('0), .rd_data(rd_data8),
        .empty(empty8), .full(full8), .credit_limit(credit_limit8),
        .fc_valid(fc_valid8), .fc_type(fc_type8), .fc_credit(fc_credit8),
        .fc_ready(fc_ready8), .overflow_err(overflow_err8),
        .type_err(type_err8)
    );

    // Record every accepted UpdateFC of the main instance.
    always @(posedge clk) begin
        if (!rst) begin
            if (fc_valid) fcv_cycles++;
            if (fc_valid && fc_ready) begin
                mon_t.push_back(int'(fc_type));
                mon_c.push_back(int'(fc_credit));
                mon_last[fc_type] = fc_credit;
                mon_seen[fc_type] = 1'b1;
            end
        end
    end

    // Record accepted UpdateFCs of the short-period instance with timestamps.
    always @(posedge clk) begin
        if (rst8) cyc8 = 0;
        else begin
            cyc8++;
            if (fc_valid8 && fc_ready8) begin
                mon8_t.push_back(int'(fc_type8));
                mon8_c.push_back(int'(fc_credit8));
                mon8_cyc.push_back(cyc8);
            end
        end
    end

    function automatic logic [DW-1:0] rdw(int i);
        return rd_data[i*DW +: DW];
    endfunction

    function automatic logic [CW-1:0] cl(int i);
        return credit_limit[i*CW +: CW];
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_clear();
        mon_t.delete();
        mon_c.delete();
        fcv_cycles = 0;
        for (int i = 0; i < NT; i++) begin
            mon_last[i] = '0;
            mon_seen[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_type = '0;
        in_data = '0;
        rd_en = '0;
        fc_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic write_one(int t, logic [DW-1:0] d);
        in_valid = 1'b1;
        in_type = TYPE_W'(t);
        in_data = d;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        in_type = PH;
        #1;
        n_chk++;
        if (empty !== '1) begin
            n_fail++; $display("FAIL reset_empty got %b want all ones", empty);
        end
        n_chk++;
        if (full !== '0) begin
            n_fail++; $display("FAIL reset_full got %b want 0", full);
        end
        n_chk++;
        if (credit_limit !== {NT{CW'(DEPTH)}}) begin
            n_fail++; $display("FAIL reset_credit got %h want all 16", credit_limit);
        end
        n_chk++;
        if ({fc_valid, fc_type, fc_credit} !== '0) begin
            n_fail++;
            $display("FAIL reset_fc got v=%b t=%0d c=%0d want 0", fc_valid, fc_type, fc_credit);
        end
        n_chk++;
        if (rd_data !== '0) begin
            n_fail++; $display("FAIL reset_rd_data got %h want 0", rd_data);
        end
        n_chk++;
        if ({overflow_err, type_err} !== '0) begin
            n_fail++; $display("FAIL reset_err got %b %b want 0", overflow_err, type_err);
        end
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] q[$];
        logic [DW-1:0] d;
        do_reset();
        fc_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            d = DW'($urandom);
            q.push_back(d);
            write_one(int'(PD), d);
        end
        in_type = PD;
        #1;
        n_chk++;
        if (full[1] !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL ovf_full got full=%b rdy=%b want 1 0", full[1], in_ready);
        end
        write_one(int'(PD), 8'hA5);
        n_chk++;
        if (overflow_err !== 6'b000010) begin
            n_fail++; $display("FAIL ovf_sticky got %b want 000010", overflow_err);
        end
        rd_en = 6'b000010;
        for (int i = 0; i < DEPTH; i++) begin
            cycle();
            n_chk++;
            if (rdw(1) !== q[i]) begin
                n_fail++; $display("FAIL ovf_rd[%0d] got %h want %h", i, rdw(1), q[i]);
            end
        end
        rd_en = '0;
        n_chk++;
        if (empty[1] !== 1'b1 || cl(1) !== CW'(32)) begin
            n_fail++; $display("FAIL ovf_drop got empty=%b cl=%0d want 1 32", empty[1], cl(1));
        end
    endtask

    task automatic test_coalesce();
        do_reset();
        fc_ready = 1'b1;
        for (int i = 0; i < 3; i++) write_one(int'(NPH), DW'(i));
        n_chk++;
        if (cl(2) !== CW'(16)) begin
            n_fail++; $display("FAIL coal_cl0 got %0d want 16", cl(2));
        end
        mon_clear();
        for (int k = 1; k <= 3; k++) begin
            rd_en = 6'b000100;
            cycle();
            n_chk++;
            if (cl(2) !== CW'(16 + k)) begin
                n_fail++; $display("FAIL coal_cl%0d got %0d want %0d", k, cl(2), 16 + k);
            end
        end
        rd_en = '0;
        repeat (10) cycle();
        n_chk++;
        if (mon_t.size() < 1 || mon_t.max() != mon_t.min() || mon_t[0] != 2) begin
            n_fail++; $display("FAIL coal_type got n=%0d want only type 2", mon_t.size());
        end else begin
            n_chk++;
            if (mon_c[$] != 19) begin
                n_fail++; $display("FAIL coal_last got %0d want 19", mon_c[$]);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        fc_ready = 1'b1;
        write_one(int'(PH), 8'h11);
        write_one(int'(CPLD), 8'h55);
        mon_clear();
        rd_en = 6'b100001;
        cycle();
        rd_en = '0;
        repeat (8) cycle();
        n_chk++;
        if (mon_t.size() != 2) begin
            n_fail++; $display("FAIL rr_count got %0d want 2", mon_t.size());
        end else begin
            n_chk++;
            if (mon_t[0] != 0 || mon_c[0] != 17 || mon_t[1] != 5 || mon_c[1] != 17) begin
                n_fail++;
                $display("FAIL rr_order got (%0d,%0d)(%0d,%0d) want (0,17)(5,17)",
                         mon_t[0], mon_c[0], mon_t[1], mon_c[1]);
            end
        end
        n_chk++;
        if (fcv_cycles != 2) begin
            n_fail++; $display("FAIL rr_send_cycles got %0d want 2", fcv_cycles);
        end
    endtask

    task automatic test_backpressure();
        int waited;
        bit bad;
        logic [TYPE_W-1:0] t0;
        logic [CW-1:0] c0;
        do_reset();
        write_one(int'(PH), 8'h01);
        write_one(int'(PH), 8'h02);
        mon_clear();
        rd_en = 6'b000001;
        cycle();
        rd_en = '0;
        waited = 0;
        while (!fc_valid && waited < 5) begin
            cycle();
            waited++;
        end
        n_chk++;
        if (fc_valid !== 1'b1 || fc_type !== PH || fc_credit !== CW'(17)) begin
            n_fail++;
            $display("FAIL bp_start got v=%b t=%0d c=%0d want 1 0 17", fc_valid, fc_type, fc_credit);
        end
        t0 = fc_type;
        c0 = fc_credit;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rd_en = (i == 3) ? 6'b000001 : '0;
            cycle();
            if (fc_valid !== 1'b1 || fc_type !== t0 || fc_credit !== c0) bad = 1'b1;
        end
        rd_en = '0;
        n_chk++;
        if (bad) begin
            n_fail++; $display("FAIL bp_stable got change while stalled want hold t=%0d c=%0d", t0, c0);
        end
        fc_ready = 1'b1;
        repeat (6) cycle();
        n_chk++;
        if (mon_t.size() != 2) begin
            n_fail++; $display("FAIL bp_count got %0d want 2", mon_t.size());
        end else begin
            n_chk++;
            if (mon_t[0] != 0 || mon_c[0] != 17 || mon_t[1] != 0 || mon_c[1] != 18) begin
                n_fail++;
                $display("FAIL bp_seq got (%0d,%0d)(%0d,%0d) want (0,17)(0,18)",
                         mon_t[0], mon_c[0], mon_t[1], mon_c[1]);
            end
        end
    endtask

    task automatic test_wrap_errors();
        logic [NT-1:0] e0, f0;
        int waited;
        do_reset();
        fc_ready = 1'b1;
        write_one(int'(NPD), 8'h33);
        in_valid = 1'b1;
        in_type = NPD;
        rd_en = 6'b001000;
        for (int n = 0; n < 4079; n++) begin
            in_data = DW'($urandom);
            cycle();
        end
        n_chk++;
        if (cl(3) !== CW'(4095)) begin
            n_fail++; $display("FAIL wrap_max got %0d want 4095", cl(3));
        end
        cycle();
        in_valid = 1'b0;
        rd_en = '0;
        n_chk++;
        if (cl(3) !== '0 || empty[3] !== 1'b0) begin
            n_fail++; $display("FAIL wrap_zero got cl=%0d empty=%b want 0 0", cl(3), empty[3]);
        end
        e0 = empty;
        f0 = full;
        in_type = 3'd7;
        in_valid = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL terr_ready got %b want 0", in_ready);
        end
        cycle();
        in_valid = 1'b0;
        n_chk++;
        if (type_err !== 1'b1 || empty !== e0 || full !== f0 || overflow_err !== '0) begin
            n_fail++;
            $display("FAIL terr_drop got te=%b e=%b f=%b ov=%b want 1 %b %b 0",
                     type_err, empty, full, overflow_err, e0, f0);
        end
        fc_ready = 1'b0;
        repeat (20) cycle();
        rd_en = 6'b001000;
        cycle();
        rd_en = '0;
        waited = 0;
        while (!fc_valid && waited < 5) begin
            cycle();
            waited++;
        end
        n_chk++;
        if (fc_valid !== 1'b1) begin
            n_fail++; $display("FAIL rst_send_enter got %b want 1", fc_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (fc_valid !== 1'b0 || fc_credit !== '0 || type_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async got v=%b c=%0d te=%b want 0 0 0", fc_valid, fc_credit, type_err);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        fc_ready = 1'b1;
        mon_clear();
        repeat (10) cycle();
        n_chk++;
        if (mon_t.size() != 0) begin
            n_fail++; $display("FAIL rst_replay got %0d UpdateFCs want 0", mon_t.size());
        end
    endtask

    task automatic test_periodic();
        bit ok;
        fc_ready8 = 1'b1;
        rst8 = 1'b1;
        mon8_t.delete();
        mon8_c.delete();
        mon8_cyc.delete();
        repeat (2) @(posedge clk);
        #1 rst8 = 1'b0;
        repeat (40) cycle();
        n_chk++;
        if (mon8_t.size() < 6) begin
            n_fail++; $display("FAIL per_count got %0d want >= 6", mon8_t.size());
        end else begin
            ok = 1'b1;
            for (int i = 0; i < 6; i++) begin
                if (mon8_t[i] != i || mon8_c[i] != 16) ok = 1'b0;
            end
            n_chk++;
            if (!ok) begin
                n_fail++;
                $display("FAIL per_seq got first (%0d,%0d) want types 0..5 credit 16",
                         mon8_t[0], mon8_c[0]);
            end
            n_chk++;
            if (mon8_cyc[0] < 8) begin
                n_fail++; $display("FAIL per_first got cycle %0d want >= 8", mon8_cyc[0]);
            end
        end
        rst8 = 1'b1;
    endtask

    task automatic test_random();
        logic [DW-1:0] mq [NT][$];
        logic [DW-1:0] exp_rd [NT];
        logic [CW-1:0] exp_cl [NT];
        logic [NT-1:0] exp_ovf, rdok, e_exp, f_exp;
        logic [NT*DW-1:0] rd_exp;
        logic [NT*CW-1:0] cl_exp;
        bit touched [NT];
        bit exp_terr, exp_ready, bad;
        int t, rprob;
        do_reset();
        mon_clear();
        exp_ovf = '0;
        exp_terr = 1'b0;
        for (int i = 0; i < NT; i++) begin
            exp_rd[i] = '0;
            exp_cl[i] = CW'(DEPTH);
            touched[i] = 1'b0;
        end
        for (int c = 0; c < 400; c++) begin
            rprob = (c < 200) ? 16 : 2;
            t = ($urandom % 10 == 0) ? 6 + int'($urandom % 2) : int'($urandom % 6);
            in_valid = ($urandom % 3) != 0;
            in_type = TYPE_W'(t);
            in_data = DW'($urandom);
            for (int i = 0; i < NT; i++) rd_en[i] = ($urandom % rprob) == 0;
            fc_ready = $urandom % 2;
            #1;
            exp_ready = (t < NT) && (mq[t].size() < DEPTH);
            n_chk++;
            if (in_ready !== exp_ready) begin
                n_fail++; $display("FAIL rnd_ready c=%0d got %b want %b", c, in_ready, exp_ready);
            end
            for (int i = 0; i < NT; i++) rdok[i] = rd_en[i] && (mq[i].size() > 0);
            cycle();
            for (int i = 0; i < NT; i++) begin
                if (rdok[i]) begin
                    exp_rd[i] = mq[i].pop_front();
                    exp_cl[i] = exp_cl[i] + 1'b1;
                    touched[i] = 1'b1;
                end
            end
            if (in_valid && exp_ready) mq[t].push_back(in_data);
            else if (in_valid && t < NT) exp_ovf[t] = 1'b1;
            else if (in_valid) exp_terr = 1'b1;
            for (int i = 0; i < NT; i++) begin
                e_exp[i] = (mq[i].size() == 0);
                f_exp[i] = (mq[i].size() == DEPTH);
                rd_exp[i*DW +: DW] = exp_rd[i];
                cl_exp[i*CW +: CW] = exp_cl[i];
            end
            bad = (empty !== e_exp) || (full !== f_exp);
            n_chk++;
            if (bad) begin
                n_fail++;
                $display("FAIL rnd_flags c=%0d got e=%b f=%b want e=%b f=%b", c, empty, full, e_exp, f_exp);
            end
            n_chk++;
            if (rd_data !== rd_exp) begin
                n_fail++; $display("FAIL rnd_rd c=%0d got %h want %h", c, rd_data, rd_exp);
            end
            n_chk++;
            if (credit_limit !== cl_exp) begin
                n_fail++; $display("FAIL rnd_credit c=%0d got %h want %h", c, credit_limit, cl_exp);
            end
            n_chk++;
            if (overflow_err !== exp_ovf || type_err !== exp_terr) begin
                n_fail++;
                $display("FAIL rnd_err c=%0d got %b %b want %b %b", c, overflow_err, type_err, exp_ovf, exp_terr);
            end
        end
        in_valid = 1'b0;
        rd_en = '0;
        fc_ready = 1'b1;
        repeat (30) cycle();
        for (int i = 0; i < NT; i++) begin
            if (touched[i]) begin
                n_chk++;
                if (!mon_seen[i] || mon_last[i] !== exp_cl[i]) begin
                    n_fail++;
                    $display("FAIL rnd_fc_last t=%0d got seen=%0d c=%0d want %0d",
                             i, mon_seen[i], mon_last[i], exp_cl[i]);
                end
            end
        end
    endtask

    initial begin
        mon_clear();
        test_reset();
        test_overflow();
        test_coalesce();
        test_round_robin();
        test_backpressure();
        test_wrap_errors();
        test_periodic();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
